// File: rtl/x_parity_chk32_pkg.sv
// Shared constants and helpers for the 32-bit parity checker.
// Used by the checker RTL and by generator-side models.
package x_parity_pkg;

    localparam int DATA_W = 32;
    localparam int BYTES  = 4;

    // XOR reduction of one byte; the checker folds four of these into word parity.
    function automatic logic byte_par(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/x_parity_chk32_if.sv
// Stream interface of x_parity_chk32: upstream word+parity, downstream
// word+error flag, plus error-status and clear signals.
// slave = checker view, master = producer/consumer (bench or system) view.
interface x_parity_chk32_if #(
    parameter int CNT_W = 8
);
    import x_parity_pkg::*;

    logic              i_valid;
    logic              i_ready;
    logic [DATA_W-1:0] i_data;
    logic              i_par;

    logic              o_valid;
    logic              o_ready;
    logic [DATA_W-1:0] o_data;
    logic              o_err;

    logic              err_sticky;
    logic [CNT_W-1:0]  err_cnt;
    logic              clr_err;

    modport slave (
        input  i_valid, i_data, i_par, o_ready, clr_err,
        output i_ready, o_valid, o_data, o_err, err_sticky, err_cnt
    );

    modport master (
        output i_valid, i_data, i_par, o_ready, clr_err,
        input  i_ready, o_valid, o_data, o_err, err_sticky, err_cnt
    );

endinterface

// File: rtl/x_parity_chk32_err_counter.sv
// Saturating bad-word counter with sticky flag.
// A clear in the same cycle as a new error leaves one error recorded.
module x_err_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             sticky
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Clear restarts the count; a simultaneous error is counted after the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            sticky <= 1'b0;
        end else if (clr) begin
            cnt    <= inc ? CNT_W'(1) : '0;
            sticky <= inc;
        end else if (inc) begin
            sticky <= 1'b1;
            if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/x_parity_chk32.sv
// x_parity_chk32: two-stage receive-side parity checker for 32-bit words.
// Stage 1 captures the word, its parity bit and four byte partials; stage 2
// is the output register holding the word and its error flag.
// Optional macro X_PARCHK_DROP_EN: bad words are counted but not presented
// (O_VALID stays low, O_ERR tied 0). Undefined: bad words are forwarded
// with O_ERR=1.
module x_parity_chk32
    import x_parity_pkg::*;
#(
    parameter bit PARITY_ODD = 1'b0,
    parameter int CNT_W      = 8
) (
    input logic             clk,
    input logic             rst_n,
    x_parity_chk32_if.slave bus
);

    // Stage 1 state.
    logic              s1_v;
    logic [DATA_W-1:0] s1_data;
    logic              s1_par;
    logic [BYTES-1:0]  s1_part;

    // Stage 2 (output) state.
    logic              o_valid_reg;
    logic [DATA_W-1:0] o_data_reg;

    // Byte partials computed on the incoming word.
    logic [BYTES-1:0]  part_in;

    logic in_xfer;
    logic s2_free;
    logic s1_adv;
    logic s1_bad;
    logic load_bad;

    for (genvar gi = 0; gi < BYTES; gi++) begin : g_part
        assign part_in[gi] = byte_par(bus.i_data[8*gi +: 8]);
    end

    // Output slot can take a word when empty or being accepted this edge.
    assign s2_free  = !o_valid_reg || bus.o_ready;
    assign s1_adv   = s1_v && s2_free;
    assign s1_bad   = (^s1_part) ^ s1_par ^ PARITY_ODD;
    assign load_bad = s1_adv && s1_bad;

    // No skid buffer: ready follows the output handshake combinationally.
    assign bus.i_ready = !s1_v || s2_free;
    assign in_xfer     = bus.i_valid && bus.i_ready;

    // Stage 1: capture on input transfer, empty when advancing with no new word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s1_data <= '0;
            s1_par  <= 1'b0;
            s1_part <= '0;
        end else if (in_xfer) begin
            s1_v    <= 1'b1;
            s1_data <= bus.i_data;
            s1_par  <= bus.i_par;
            s1_part <= part_in;
        end else if (s1_adv) begin
            s1_v    <= 1'b0;
        end
    end

`ifdef X_PARCHK_DROP_EN

    // Stage 2: only good words are presented; a bad word frees its slot at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid_reg <= 1'b0;
            o_data_reg  <= '0;
        end else if (s1_adv) begin
            o_valid_reg <= !s1_bad;
            if (!s1_bad) begin
                o_data_reg <= s1_data;
            end
        end else if (bus.o_ready) begin
            o_valid_reg <= 1'b0;
        end
    end

    assign bus.o_err = 1'b0;

`else

    logic o_err_reg;

    // Stage 2: every word is presented along with its parity verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid_reg <= 1'b0;
            o_data_reg  <= '0;
            o_err_reg   <= 1'b0;
        end else if (s1_adv) begin
            o_valid_reg <= 1'b1;
            o_data_reg  <= s1_data;
            o_err_reg   <= s1_bad;
        end else if (bus.o_ready) begin
            o_valid_reg <= 1'b0;
        end
    end

    assign bus.o_err = o_err_reg;

`endif

    assign bus.o_valid = o_valid_reg;
    assign bus.o_data  = o_data_reg;

    // Errors are accounted when a bad word enters stage 2, so each counts once.
    x_err_counter #(
        .CNT_W (CNT_W)
    ) u_err (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (load_bad),
        .clr    (bus.clr_err),
        .cnt    (bus.err_cnt),
        .sticky (bus.err_sticky)
    );

endmodule

// File: tb/tb_x_parity_chk32.sv
// Bench for x_parity_chk32: two instances (even parity/8-bit counter and
// odd parity/2-bit counter), a queue-based model of each and a per-cycle
// compare process, plus directed checks with literal expectations.
// Honours X_PARCHK_DROP_EN when the build defines it.
module tb_x_parity_chk32;
    import x_parity_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        iv   [2];
    logic [31:0] idat [2];
    logic        ipar [2];
    logic        ordy [2];
    logic        clr  [2];

    wire         irdy [2];
    wire         ov   [2];
    wire  [31:0] odat [2];
    wire         oerr [2];
    wire         stk  [2];
    wire  [15:0] cnt  [2];

    int n_vec = 0;
    int n_err = 0;
    int n_out1 = 0;

    x_parity_chk32_if #(.CNT_W(8)) bus0 ();
    x_parity_chk32_if #(.CNT_W(2)) bus1 ();

    assign bus0.i_valid = iv[0];
    assign bus0.i_data  = idat[0];
    assign bus0.i_par   = ipar[0];
    assign bus0.o_ready = ordy[0];
    assign bus0.clr_err = clr[0];
    assign irdy[0] = bus0.i_ready;
    assign ov[0]   = bus0.o_valid;
    assign odat[0] = bus0.o_data;
    assign oerr[0] = bus0.o_err;
    assign stk[0]  = bus0.err_sticky;
    assign cnt[0]  = 16'(bus0.err_cnt);

    assign bus1.i_valid = iv[1];
    assign bus1.i_data  = idat[1];
    assign bus1.i_par   = ipar[1];
    assign bus1.o_ready = ordy[1];
    assign bus1.clr_err = clr[1];
    assign irdy[1] = bus1.i_ready;
    assign ov[1]   = bus1.o_valid;
    assign odat[1] = bus1.o_data;
    assign oerr[1] = bus1.o_err;
    assign stk[1]  = bus1.err_sticky;
    assign cnt[1]  = 16'(bus1.err_cnt);

    x_parity_chk32 #(.PARITY_ODD(1'b0), .CNT_W(8)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    x_parity_chk32 #(.PARITY_ODD(1'b1), .CNT_W(2)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    // ---------------- behavioural model ----------------
    // Each DUT is a two-deep in-order queue of words. The head is shown at
    // the output once it has waited at least one edge and the output is free.
    wire        m_pres [2];
    wire        m_pend [2];
    wire [31:0] m_hd   [2];
    wire        m_hbad [2];
    wire [15:0] m_cnt  [2];
    wire        m_stk  [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_model
        localparam int ODD  = (gi == 1) ? 1 : 0;
        localparam int MAXC = (gi == 1) ? 3 : 255;
        logic [32:0] q[$];
        bit          pres;
        bit          pend;
        int          cntm;
        bit          stkm;
        logic [31:0] hd;
        bit          hbad;
        bit          xfer;
        bit          loadbad;
        bit          bad;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q.delete();
                pres = 1'b0;
                cntm = 0;
                stkm = 1'b0;
            end else begin
                xfer    = iv[gi] && irdy[gi];
                bad     = ((($countones(idat[gi]) + int'(ipar[gi])) % 2) != ODD);
                loadbad = 1'b0;
                if (pres && ordy[gi]) begin
                    void'(q.pop_front());
                    pres = 1'b0;
                end
                if (!pres && q.size() > 0) begin
                    loadbad = q[0][32];
`ifdef X_PARCHK_DROP_EN
                    if (loadbad) void'(q.pop_front());
                    else pres = 1'b1;
`else
                    pres = 1'b1;
`endif
                end
                if (clr[gi]) begin
                    cntm = loadbad ? 1 : 0;
                    stkm = loadbad;
                end else if (loadbad) begin
                    stkm = 1'b1;
                    if (cntm < MAXC) cntm++;
                end
                if (xfer) q.push_back({bad, idat[gi]});
            end
            pend = (q.size() > (pres ? 1 : 0));
            hd   = (q.size() > 0) ? q[0][31:0] : 32'h0;
            hbad = (q.size() > 0) ? q[0][32] : 1'b0;
        end

        assign m_pres[gi] = pres;
        assign m_pend[gi] = pend;
        assign m_hd[gi]   = hd;
        assign m_hbad[gi] = hbad;
        assign m_cnt[gi]  = 16'(cntm);
        assign m_stk[gi]  = stkm;
    end

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d t=%0t: got %h expected %h", nm, d, $time, act, exp);
        end
    endtask

    // Per-cycle compare against the model, mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                chk("i_ready", d, 32'(irdy[d]), 32'(!(m_pend[d] && m_pres[d] && !ordy[d])));
                chk("o_valid", d, 32'(ov[d]), 32'(m_pres[d]));
                if (m_pres[d]) chk("o_data", d, odat[d], m_hd[d]);
`ifdef X_PARCHK_DROP_EN
                chk("o_err", d, 32'(oerr[d]), 32'd0);
`else
                if (m_pres[d]) chk("o_err", d, 32'(oerr[d]), 32'(m_hbad[d]));
`endif
                chk("err_cnt", d, 32'(cnt[d]), 32'(m_cnt[d]));
                chk("err_sticky", d, 32'(stk[d]), 32'(m_stk[d]));
            end
        end
    end

    // Output acceptances on the odd-parity instance.
    always @(posedge clk) begin
        if (rst_n && ov[1] && ordy[1]) n_out1++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one word and return 1 ns after the edge that accepted it.
    task automatic send(input int d, input logic [31:0] data, input logic par);
        logic r;
        bit   done;
        done    = 1'b0;
        iv[d]   = 1'b1;
        idat[d] = data;
        ipar[d] = par;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            r = irdy[d];
            @(posedge clk);
            #1;
            if (r) done = 1'b1;
        end
        iv[d] = 1'b0;
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout dut%0d: word %h not accepted within 50 cycles", d, data);
        end
    endtask

    task automatic hold_check(input logic [31:0] w);
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready_low", 0, 32'(irdy[0]), 32'd0);
            chk("bp_valid", 0, 32'(ov[0]), 32'd1);
            chk("bp_data_hold", 0, odat[0], w);
        end
        @(posedge clk);
        #1;
        ordy[0] = 1'b1;
    endtask

    int base_out;

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0; idat[d] = '0; ipar[d] = 1'b0; ordy[d] = 1'b1; clr[d] = 1'b0;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_o_valid", d, 32'(ov[d]), 32'd0);
            chk("rst_o_data", d, odat[d], 32'd0);
            chk("rst_o_err", d, 32'(oerr[d]), 32'd0);
            chk("rst_err_cnt", d, 32'(cnt[d]), 32'd0);
            chk("rst_sticky", d, 32'(stk[d]), 32'd0);
        end
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // Good words, even parity, latency check on the first.
        send(0, 32'h0000_0001, 1'b1);
        @(negedge clk);
        chk("lat_cycle1_valid", 0, 32'(ov[0]), 32'd0);
        @(negedge clk);
        chk("lat_cycle2_valid", 0, 32'(ov[0]), 32'd1);
        chk("lat_cycle2_data", 0, odat[0], 32'h0000_0001);
        chk("lat_cycle2_err", 0, 32'(oerr[0]), 32'd0);
        @(posedge clk);
        #1;
        send(0, 32'hFFFF_FFFF, 1'b0);
        tick(3);
        chk("good_err_cnt", 0, 32'(cnt[0]), 32'd0);
        chk("good_sticky", 0, 32'(stk[0]), 32'd0);

        // Single bad word, then clear coinciding with another bad load.
        send(0, 32'h8000_0000, 1'b0);
        tick(1);
        chk("bad_err_cnt", 0, 32'(cnt[0]), 32'd1);
        chk("bad_sticky", 0, 32'(stk[0]), 32'd1);
`ifndef X_PARCHK_DROP_EN
        @(negedge clk);
        chk("bad_o_err", 0, 32'(oerr[0]), 32'd1);
        chk("bad_o_data", 0, odat[0], 32'h8000_0000);
        @(posedge clk);
        #1;
`endif
        send(0, 32'h8000_0000, 1'b0);
        clr[0] = 1'b1;
        tick(1);
        clr[0] = 1'b0;
        chk("clr_vs_err_cnt", 0, 32'(cnt[0]), 32'd1);
        chk("clr_vs_err_sticky", 0, 32'(stk[0]), 32'd1);
        tick(1);
        clr[0] = 1'b1;
        tick(1);
        clr[0] = 1'b0;
        chk("clr_cnt", 0, 32'(cnt[0]), 32'd0);
        chk("clr_sticky", 0, 32'(stk[0]), 32'd0);

        // Backpressure: two words fill the pipe, third waits for O_READY.
        ordy[0] = 1'b0;
        send(0, 32'h0000_0003, 1'b0);
        send(0, 32'h1234_5678, 1'b1);
        fork
            send(0, 32'hA5A5_A5A5, 1'b0);
            hold_check(32'h0000_0003);
        join
        tick(4);
        chk("bp_drained_valid", 0, 32'(ov[0]), 32'd0);

        // Saturation on the 2-bit counter (odd parity: data 0, par 0 is bad).
        for (int k = 0; k < 5; k++) begin
            send(1, 32'h0000_0000, 1'b0);
            tick(1);
            chk("sat_err_cnt", 1, 32'(cnt[1]), (k < 3) ? 32'(k + 1) : 32'd3);
        end
        tick(2);
        clr[1] = 1'b1;
        tick(1);
        clr[1] = 1'b0;
        chk("sat_clr_cnt", 1, 32'(cnt[1]), 32'd0);
        chk("sat_clr_sticky", 1, 32'(stk[1]), 32'd0);

        // Asynchronous reset with the pipe loaded.
        ordy[0] = 1'b0;
        send(0, 32'h8000_0000, 1'b0);
        send(0, 32'h0000_0003, 1'b0);
        chk("pre_rst_cnt", 0, 32'(cnt[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 0, 32'(ov[0]), 32'd0);
        chk("async_rst_cnt", 0, 32'(cnt[0]), 32'd0);
        chk("async_rst_sticky", 0, 32'(stk[0]), 32'd0);
        chk("async_rst_data", 0, odat[0], 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ordy[0] = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 0, 32'(irdy[0]), 32'd1);
        @(posedge clk);
        #1;
        send(0, 32'h0000_0055, 1'b0);
        @(negedge clk);
        chk("post_rst_lat1", 0, 32'(ov[0]), 32'd0);
        @(negedge clk);
        chk("post_rst_lat2", 0, 32'(ov[0]), 32'd1);
        chk("post_rst_data", 0, odat[0], 32'h0000_0055);
        @(posedge clk);
        #1;

        // Odd parity: one good, one bad word of the same data.
        base_out = n_out1;
        send(1, 32'h0000_0003, 1'b1);
        send(1, 32'h0000_0003, 1'b0);
        tick(4);
        chk("odd_err_cnt", 1, 32'(cnt[1]), 32'd1);
`ifdef X_PARCHK_DROP_EN
        chk("odd_outputs", 1, 32'(n_out1 - base_out), 32'd1);
`else
        chk("odd_outputs", 1, 32'(n_out1 - base_out), 32'd2);
`endif

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/x_parity_chk32.md
Name: x_parity_chk32

Overview:
- Receive-side counterpart of the 32-input XOR parity generator cell: checks a 32-bit word against its transmitted parity bit.
- Two-stage pipeline with valid/ready handshakes on both sides.
- Forwards each word with a per-word error flag, a sticky error flag and a saturating error counter.
- Sits on the consumer end of any path protected by the 32-bit parity generator.

Parameters:
- PARITY_ODD, 0, 0 = even parity (XOR of data and parity is 0 when good); 1 = odd parity (XOR is 1 when good).
- CNT_W, 8, width of the error counter, range 1..16.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- I_VALID  input  1  upstream word valid.
- I_READY  output  1  block can accept a word.
- I_DATA  input  32  received data word.
- I_PAR  input  1  received parity bit.
- O_VALID  output  1  checked word valid.
- O_READY  input  1  downstream accepts the word.
- O_DATA  output  32  checked data word, unchanged from input.
- O_ERR  output  1  parity mismatch for the current O_DATA.
- ERR_STICKY  output  1  set by any accepted bad word; cleared by CLR_ERR.
- ERR_CNT  output  CNT_W  count of bad words, saturating.
- CLR_ERR  input  1  synchronous clear of ERR_STICKY and ERR_CNT.

Behaviour:
- Reset (RST_N low, asynchronous) takes effect immediately:
  - O_VALID=0, O_ERR=0, O_DATA=0, ERR_STICKY=0, ERR_CNT=0.
  - Both stage-valid bits cleared; any in-flight words are discarded.
  - I_READY=1 from the first edge after reset release.
- Transfers: a transfer occurs when VALID and READY are both high at a rising edge.
  - Once asserted, O_VALID, O_DATA and O_ERR hold until accepted.
- Stage 1 (s1):
  - On input transfer, registers I_DATA, I_PAR and four byte partials p[k] = XOR of I_DATA[8k+7:8k].
  - s1_v marks stage 1 occupied.
- Stage 2 (output registers):
  - Loads s1 when s1_v=1 and (O_VALID=0 or O_READY=1).
  - O_ERR = p0^p1^p2^p3^s1_par^PARITY_ODD.
- Flow control:
  - I_READY = !s1_v | (!O_VALID | O_READY). This is combinational from O_READY; there is no skid buffer.
  - Full throughput is 1 word/cycle when O_READY is held high.
  - Latency is 2 cycles from input transfer to O_VALID.
  - Simultaneous input transfer and s1 advance: s1 reloads in the same edge; s1_v stays 1.
  - s1 advances with no new input: s1_v goes to 0.
- Error accounting happens on the stage-2 load of a bad word (not on output acceptance), so each bad word is counted exactly once:
  - ERR_STICKY goes to 1.
  - ERR_CNT increments, saturating at 2^CNT_W-1 (no wrap).
- CLR_ERR:
  - With no bad-word load in the same cycle: ERR_CNT becomes 0 and ERR_STICKY becomes 0.
  - With a bad-word load in the same cycle: ERR_CNT becomes 1 and ERR_STICKY becomes 1; the new error wins over the clear.
  - CLR_ERR has no effect on data flow.
- Backpressure: while O_VALID=1 and O_READY=0, s1 holds if full. I_READY=0 only when both stages are full.

Optional Feature:
- Macro: X_PARCHK_DROP_EN.
- Defined:
  - A bad word is still counted at stage-2 load and still sets ERR_STICKY.
  - It is not presented: O_VALID stays 0 and the slot is freed in the same cycle.
  - O_ERR is tied to 0.
- Undefined: bad words are forwarded with O_ERR=1, as described above.

Decomposition:
- Package x_parity_pkg:
  - constant DATA_W=32.
  - constant BYTES=4.
  - function byte_par(logic [7:0]) returning the XOR reduction, shared with the generator-side testbench model.
- Sub-module x_err_counter: saturating counter of width CNT_W with inc, clr and sticky flag; it owns the clear/increment priority rule.
- The pipeline stays in the top module.

Test Plan:
- Even parity, O_READY=1: send 0x0000_0001 with I_PAR=1, then 0xFFFF_FFFF with I_PAR=0 → both appear 2 cycles later with O_ERR=0; ERR_CNT=0.
- Send 0x8000_0000 with I_PAR=0 → O_ERR=1, ERR_STICKY=1, ERR_CNT=1. Assert CLR_ERR on the same edge as the next bad word → ERR_CNT=1 (new error counted).
- Hold O_READY=0 and stream 3 words → I_READY drops after 2 accepted. O_DATA is stable until O_READY=1; then the words drain in order with no loss or duplication.
- CNT_W=2: inject 5 bad words → ERR_CNT reads 1,2,3,3,3; one CLR_ERR with no error in that cycle → ERR_CNT=0, ERR_STICKY=0.
- Assert RST_N=0 mid-stream with both stages full → O_VALID=0 and ERR_CNT=0 immediately (asynchronous); after release, I_READY=1 and the next word has 2-cycle latency.
- PARITY_ODD=1 with X_PARCHK_DROP_EN defined: send 0x0000_0003 with I_PAR=1 (good) and 0x0000_0003 with I_PAR=0 (bad) → only the first word is output; ERR_CNT=1.
